// File: rtl/ack_bus_pkg.sv
// Shared definitions for the ack bus request sources: bus IDs, source FSM states and
// default sizing constants.
package ack_bus_pkg;

  localparam logic [1:0] ACK_ID_MEM  = 2'b00;
  localparam logic [1:0] ACK_ID_SHA  = 2'b01;
  localparam logic [1:0] ACK_ID_AES  = 2'b10;
  localparam logic [1:0] ACK_ID_CTRL = 2'b11;

  localparam int unsigned ACK_DEF_MAX_PENDING    = 4;
  localparam int unsigned ACK_DEF_HOLDOFF_CYCLES = 2;
  localparam int unsigned ACK_DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } ack_src_state_t;

endpackage

// File: rtl/ack_pending_counter.sv
// Saturating up/down counter of outstanding acks; simultaneous inc/dec cancel, and an inc
// that arrives at saturation without a dec is dropped and flagged (sticky).
module ack_pending_counter
  import ack_bus_pkg::*;
#(
  parameter int unsigned MAX_COUNT = ACK_DEF_MAX_PENDING,
  localparam int unsigned CW = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_next_o,
  output logic          overflow_o
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  logic          r_overflow;
  logic          w_overflow_set;

  always_comb begin
    w_count_d      = r_count;
    w_overflow_set = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (r_count == CW'(MAX_COUNT)) w_overflow_set = 1'b1;
        else                           w_count_d      = r_count + 1'b1;
      end
      2'b01: begin
        if (r_count != '0) w_count_d = r_count - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_count_d;
      r_overflow <= r_overflow | w_overflow_set;
    end
  end

  assign count_o      = r_count;
  assign count_next_o = w_count_d;
  assign overflow_o   = r_overflow;

endmodule

// File: rtl/ack_req_source.sv
// Per-module ack bus request source: turns done pulses into a held request with post-grant
// holdoff. Optional grant-wait timeout flag enabled by the ACK_TIMEOUT_EN macro.
module ack_req_source
  import ack_bus_pkg::*;
#(
  parameter logic [1:0]  SRC_ID         = ACK_ID_MEM,
  parameter int unsigned MAX_PENDING    = ACK_DEF_MAX_PENDING,
  parameter int unsigned HOLDOFF_CYCLES = ACK_DEF_HOLDOFF_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = ACK_DEF_TIMEOUT_CYCLES,
  localparam int unsigned PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_i,
  input  logic          ack_ready_i,
  output logic          req_o,
  output logic [PW-1:0] pending_o,
  output logic          overflow_o,
  output logic [1:0]    src_id_o,
  output logic          timeout_o
);

  localparam int unsigned HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  ack_src_state_t r_state, w_state_d;
  logic [HW-1:0]  r_hold, w_hold_d;
  logic           r_req;
  logic           w_grant;
  logic [PW-1:0]  w_count_next;

  assign w_grant = r_req & ack_ready_i;

  ack_pending_counter #(
    .MAX_COUNT (MAX_PENDING)
  ) u_pending (
    .clk          (clk),
    .rst          (rst),
    .inc_i        (done_i),
    .dec_i        (w_grant),
    .count_o      (pending_o),
    .count_next_o (w_count_next),
    .overflow_o   (overflow_o)
  );

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_count_next != '0) w_state_d = REQ;
      end
      REQ: begin
        if (w_grant) begin
          if (HOLDOFF_CYCLES == 0) begin
            w_state_d = (w_count_next != '0) ? REQ : IDLE;
          end else begin
            w_state_d = HOLDOFF;
            w_hold_d  = HW'(HOLDOFF_CYCLES - 1);
          end
        end
      end
      HOLDOFF: begin
        if (r_hold == '0) w_state_d = (w_count_next != '0) ? REQ : IDLE;
        else              w_hold_d  = r_hold - 1'b1;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hold  <= w_hold_d;
      r_req   <= (w_state_d == REQ);
    end
  end

  assign req_o    = r_req;
  assign src_id_o = SRC_ID;

`ifdef ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wait, w_wait_d;
  logic          r_timeout;

  // Wait restarts on every fresh request, including a back-to-back re-request after a grant.
  always_comb begin
    w_wait_d = r_wait;
    if (r_state != REQ || w_grant) w_wait_d = '0;
    else if (r_wait != TW'(TIMEOUT_CYCLES)) w_wait_d = r_wait + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wait    <= w_wait_d;
      r_timeout <= r_timeout | ((r_state == REQ) && !w_grant && (w_wait_d == TW'(TIMEOUT_CYCLES)));
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
